// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pkg
//  Description : Shared types and default widths for stream source/sink blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_CNT_W  = 16;
    localparam int c_GAP_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } src_state_t;

endpackage : stream_pkg
`default_nettype wire

// File: rtl/stream_source.sv
`default_nettype none
// ============================================================================
//  Module      : stream_source
//  Description : Valid/ready burst generator: base + n*step words with an
//                optional idle gap between accepted beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_source
    import stream_pkg::*;
#(
    parameter int WIDTH = c_DATA_W,
    parameter int CNT_W = c_CNT_W,
    parameter int GAP_W = c_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_base,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [GAP_W-1:0] cfg_gap,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
);

    src_state_t       r_state_q,   w_state_d;
    logic             r_valid_q,   w_valid_d;
    logic [WIDTH-1:0] r_data_q,    w_data_d;
    logic [WIDTH-1:0] r_step_q,    w_step_d;
    logic [CNT_W-1:0] r_len_q,     w_len_d;
    logic [GAP_W-1:0] r_gap_q,     w_gap_d;
    logic [GAP_W-1:0] r_gap_cnt_q, w_gap_cnt_d;
    logic [CNT_W-1:0] r_count_q,   w_count_d;
    logic             r_busy_q,    w_busy_d;
    logic             r_done_q,    w_done_d;

    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = r_count_q + CNT_W'(1);

    always_comb begin
        w_state_d   = r_state_q;
        w_valid_d   = r_valid_q;
        w_data_d    = r_data_q;
        w_step_d    = r_step_q;
        w_len_d     = r_len_q;
        w_gap_d     = r_gap_q;
        w_gap_cnt_d = r_gap_cnt_q;
        w_count_d   = r_count_q;
        w_busy_d    = r_busy_q;
        w_done_d    = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_data_d  = cfg_base;
                    w_step_d  = cfg_step;
                    w_len_d   = cfg_len;
                    w_gap_d   = cfg_gap;
                    w_count_d = '0;
                    w_busy_d  = 1'b1;
                    if (cfg_len != '0) begin
                        w_state_d = SEND;
                        w_valid_d = 1'b1;
                    end else begin
                        w_state_d = DONE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            SEND: begin
                if (r_valid_q && out_ready) begin
                    w_count_d = w_count_inc;
                    w_data_d  = r_data_q + r_step_q;
                    if (w_count_inc == r_len_q) begin
                        w_valid_d = 1'b0;
                        w_state_d = DONE;
                        w_done_d  = 1'b1;
                    end else if (r_gap_q != '0) begin
                        w_valid_d   = 1'b0;
                        w_gap_cnt_d = r_gap_q;
                        w_state_d   = GAP;
                    end
                end
            end
            GAP: begin
                // Counter starts at gap and leaves on 1, giving exactly gap idle cycles
                if (r_gap_cnt_q == GAP_W'(1)) begin
                    w_valid_d = 1'b1;
                    w_state_d = SEND;
                end else begin
                    w_gap_cnt_d = r_gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                w_busy_d  = 1'b0;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
                w_valid_d = 1'b0;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_step_q    <= '0;
            r_len_q     <= '0;
            r_gap_q     <= '0;
            r_gap_cnt_q <= '0;
            r_count_q   <= '0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_valid_q   <= w_valid_d;
            r_data_q    <= w_data_d;
            r_step_q    <= w_step_d;
            r_len_q     <= w_len_d;
            r_gap_q     <= w_gap_d;
            r_gap_cnt_q <= w_gap_cnt_d;
            r_count_q   <= w_count_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
        end
    end

    assign out_valid  = r_valid_q;
    assign out_data   = r_data_q;
    assign busy       = r_busy_q;
    assign done       = r_done_q;
    assign sent_count = r_count_q;

endmodule : stream_source
`default_nettype wire
